// File: rtl/fir_axis_sample_source.sv
// -----------------------------------------------------------------------------
// fir_axis_sample_source
//
// AXI-stream master feeding 6-bit two's-complement samples into the FIR sink.
// Samples come from slow, asynchronous pads: in_data is captured on each rising
// edge of in_strobe, buffered in a small FIFO and presented through a single
// output register that obeys the AXI-stream hold rules.
//
// Optional feature macro: FIR_SRC_PATTERN_EN
//   defined   : mode selects FIFO (00), impulse (01), step (10) or ramp (11).
//   undefined : mode is ignored, the block always runs in FIFO mode and no
//               pattern logic is built.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   in_data        in   pad sample value (asynchronous)
//   in_strobe      in   pad strobe, one push per rising edge (asynchronous)
//   mode           in   00 FIFO, 01 impulse, 10 step, 11 ramp
//   m_axis_tdata   out  sample to the FIR
//   m_axis_tvalid  out  sample valid
//   m_axis_tready  in   FIR ready
//   fifo_count     out  FIFO occupancy 0..FIFO_DEPTH (output register excluded)
//   overflow       out  sticky flag, a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module fir_axis_sample_source #(
  parameter int DATA_W     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_strobe,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

  // Pad synchroniser chain; strobe flops reset high so a strobe held across
  // reset is not mistaken for a fresh rising edge.
  logic              strobe_s1_r;
  logic              strobe_s2_r;
  logic              strobe_s3_r;
  logic [DATA_W-1:0] data_s1_r;
  logic [DATA_W-1:0] data_s2_r;

  // FIFO storage and bookkeeping.
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r;

  // Output register.
  logic [DATA_W-1:0] tdata_r;
  logic              tvalid_r;

  // Combinational control.
  logic              rise_s;
  logic              full_s;
  logic              empty_s;
  logic              can_load_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              fifo_mode_s;
  logic [DATA_W-1:0] pat_value_s;

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign fifo_count    = count_r;
  assign overflow      = overflow_r;

  // Two-flop synchronisers for strobe and data, plus the strobe edge delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_s1_r <= 1'b1;
      strobe_s2_r <= 1'b1;
      strobe_s3_r <= 1'b1;
      data_s1_r   <= DATA_ZERO;
      data_s2_r   <= DATA_ZERO;
    end else begin
      strobe_s1_r <= in_strobe;
      strobe_s2_r <= strobe_s1_r;
      strobe_s3_r <= strobe_s2_r;
      data_s1_r   <= in_data;
      data_s2_r   <= data_s1_r;
    end
  end

  // FIFO push/pop decisions; a full FIFO still accepts a push when it pops.
  always_comb begin
    rise_s     = strobe_s2_r & ~strobe_s3_r;
    full_s     = (count_r == CNT_FULL);
    empty_s    = (count_r == CNT_ZERO);
    can_load_s = ~tvalid_r | m_axis_tready;
    pop_s      = fifo_mode_s & can_load_s & ~empty_s;
    push_s     = rise_s & (~full_s | pop_s);
    drop_s     = rise_s & full_s & ~pop_s;
  end

  // FIFO storage array; contents need no reset because pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_s2_r;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

`ifdef FIR_SRC_PATTERN_EN
  typedef enum logic [0:0] {
    PAT_IDLE = 1'b0,
    PAT_RUN  = 1'b1
  } pat_state_t;

  localparam logic [DATA_W-1:0] PAT_LEVEL = DATA_W'(6'h1F);
  localparam logic [DATA_W-1:0] RAMP_ONE  = DATA_W'(1);

  pat_state_t        pat_state_r;
  logic [DATA_W-1:0] ramp_r;      // value of the next ramp beat
  logic [1:0]        mode_prev_r;
  logic              armed_s;     // next load is the first of a pattern

  // Pattern value for the next load; a mode change re-arms immediately so the
  // first beat after a switch is always the pattern's starting value.
  always_comb begin
    fifo_mode_s = (mode == 2'b00);
    armed_s     = (mode != mode_prev_r) | (pat_state_r == PAT_IDLE);
    pat_value_s = DATA_ZERO;
    case (mode)
      2'b01: begin
        if (armed_s) begin
          pat_value_s = PAT_LEVEL;
        end else begin
          pat_value_s = DATA_ZERO;
        end
      end
      2'b10: pat_value_s = PAT_LEVEL;
      2'b11: begin
        if (armed_s) begin
          pat_value_s = DATA_ZERO;
        end else begin
          pat_value_s = ramp_r;
        end
      end
      default: pat_value_s = DATA_ZERO;
    endcase
  end

  // Pattern FSM: IDLE until the first pattern load, then RUN; re-arms on mode change.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_state_r <= PAT_IDLE;
      ramp_r      <= DATA_ZERO;
      mode_prev_r <= 2'b00;
    end else begin
      mode_prev_r <= mode;
      if (~fifo_mode_s & can_load_s) begin
        pat_state_r <= PAT_RUN;
        ramp_r      <= (armed_s ? DATA_ZERO : ramp_r) + RAMP_ONE;
      end else if (mode != mode_prev_r) begin
        pat_state_r <= PAT_IDLE;
        ramp_r      <= DATA_ZERO;
      end
    end
  end
`else
  logic unused_mode_s;

  // Without pattern support the block is permanently in FIFO mode.
  always_comb begin
    fifo_mode_s   = 1'b1;
    pat_value_s   = DATA_ZERO;
    unused_mode_s = ^mode;
  end
`endif

  // Output register: loads only when empty or being accepted, so tdata/tvalid
  // are held while the FIR stalls and never depend combinationally on tready.
  always_ff @(posedge clk) begin
    if (reset) begin
      tdata_r  <= DATA_ZERO;
      tvalid_r <= 1'b0;
    end else if (fifo_mode_s) begin
      if (pop_s) begin
        tdata_r  <= mem_r[rd_ptr_r];
        tvalid_r <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_r <= 1'b0;
      end
    end else if (can_load_s) begin
      tdata_r  <= pat_value_s;
      tvalid_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_axis_sample_source.sv
// -----------------------------------------------------------------------------
// tb_fir_axis_sample_source
//
// Scoreboard bench: stimulus pushes the beats the FIR should receive into a
// queue; a monitor thread pops and compares on every tvalid & tready and also
// checks that a stalled beat is held stable.
// -----------------------------------------------------------------------------
module tb_fir_axis_sample_source;

  logic       clk;
  logic       reset;
  logic [5:0] in_data;
  logic       in_strobe;
  logic [1:0] mode;
  logic [5:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [2:0] fifo_count;
  logic       overflow;

  int         vectors;
  int         miscompares;
  int         hs_count;
  logic [5:0] exp_q[$];
  logic       ready_level;
  logic       rand_ready;

  fir_axis_sample_source #(
    .DATA_W    (6),
    .FIFO_DEPTH(4),
    .ADDR_W    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_strobe    (in_strobe),
    .mode         (mode),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pad strobe pulse; called just after a rising edge.
  task automatic strobe_pulse(input logic [5:0] val, input int hi, input int lo, input bit expect_beat);
    in_data   = val;
    in_strobe = 1'b1;
    if (expect_beat) exp_q.push_back(val);
    repeat (hi) @(posedge clk);
    #1 in_strobe = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic monitor();
    logic       prev_hold;
    logic [5:0] prev_data;
    logic [5:0] exp_v;
    prev_hold = 1'b0;
    prev_data = 6'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_tvalid", m_axis_tvalid, 1'b1);
          check("hold_tdata", m_axis_tdata, prev_data);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL beat: got unexpected beat %0h, expected none (t=%0t)", m_axis_tdata, $time);
          end else begin
            exp_v = exp_q.pop_front();
            check("beat", m_axis_tdata, exp_v);
          end
        end
        prev_hold = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #2;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  endtask

  task automatic watchdog();
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected $finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  endtask

  initial begin
    int hs0;
    logic [5:0] v;
    vectors       = 0;
    miscompares   = 0;
    hs_count      = 0;
    reset         = 1'b1;
    in_strobe     = 1'b1;
    in_data       = 6'h00;
    mode          = 2'b00;
    ready_level   = 1'b0;
    rand_ready    = 1'b0;
    m_axis_tready = 1'b0;
    fork
      monitor();
      drive_ready();
      watchdog();
    join_none

    // 1: strobe held high across reset must not push.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 6'h00);
    check("rst_count", fifo_count, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_count", fifo_count, 3'd0);
      check("t1_tvalid", m_axis_tvalid, 1'b0);
    end
    tick();
    in_strobe = 1'b0;
    repeat (4) tick();

    // 2: single sample, latency of 4 edges, one-cycle tvalid.
    ready_level = 1'b1;
    repeat (2) tick();
    hs0 = hs_count;
    in_data   = 6'h2A;
    in_strobe = 1'b1;
    exp_q.push_back(6'h2A);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      check("t2_tvalid_edge", m_axis_tvalid, (e == 4) ? 1'b1 : 1'b0);
      if (e == 4) check("t2_tdata", m_axis_tdata, 6'h2A);
      if (e == 4) in_strobe = 1'b0;
    end
    check("t2_handshakes", hs_count - hs0, 1);
    check("t2_overflow", overflow, 1'b0);
    tick();

    // 3: overflow with the FIR stalled; register + 4 FIFO entries survive.
    ready_level = 1'b0;
    repeat (2) tick();
    for (int i = 1; i <= 6; i++) strobe_pulse(6'(i), 2, 2, i <= 5);
    repeat (4) tick();
    @(negedge clk);
    check("t3_tvalid", m_axis_tvalid, 1'b1);
    check("t3_tdata", m_axis_tdata, 6'h01);
    check("t3_count", fifo_count, 3'd4);
    check("t3_overflow", overflow, 1'b1);
    tick();
    ready_level = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t3_b2b_pending", exp_q.size(), 0);
    check("t3_tvalid_after", m_axis_tvalid, 1'b0);
    tick();

    // Reset while a beat is stalled: beat and FIFO are lost, overflow cleared.
    ready_level = 1'b0;
    repeat (2) tick();
    strobe_pulse(6'h15, 2, 2, 1'b0);
    strobe_pulse(6'h2B, 2, 2, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    check("rm_tvalid_before", m_axis_tvalid, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rm_tvalid", m_axis_tvalid, 1'b0);
    check("rm_count", fifo_count, 3'd0);
    check("rm_overflow", overflow, 1'b0);
    tick();
    ready_level = 1'b1;
    repeat (10) tick();

    // 4: random tready during 3-sample bursts.
    rand_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      hs0 = hs_count;
      for (int i = 0; i < 3; i++) begin
        v = 6'($urandom);
        strobe_pulse(v, 2, 2, 1'b1);
      end
      wait_drain(200, "t4_drain");
      repeat (2) tick();
      check("t4_handshakes", hs_count - hs0, 3);
    end
    rand_ready  = 1'b0;
    ready_level = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("t4_idle_tvalid", m_axis_tvalid, 1'b0);
    tick();

`ifdef FIR_SRC_PATTERN_EN
    // 5: ramp wraps after 63, then impulse after the held ramp beat is taken.
    mode = 2'b11;
    for (int k = 0; k < 66; k++) exp_q.push_back(6'(k));
    repeat (3) tick();
    @(negedge clk);
    check("t5_first_tdata", m_axis_tdata, 6'h00);
    tick();
    ready_level = 1'b1;
    repeat (66) @(posedge clk);
    #1;
    ready_level = 1'b0;
    mode        = 2'b01;
    exp_q.push_back(6'h02);
    exp_q.push_back(6'h1F);
    repeat (3) exp_q.push_back(6'h00);
    repeat (3) tick();
    @(negedge clk);
    check("t5_ramp_pending", exp_q.size(), 5);
    check("t5_held_tdata", m_axis_tdata, 6'h02);
    tick();
    ready_level = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ready_level = 1'b0;
    exp_q.push_back(6'h00);
    strobe_pulse(6'h0B, 2, 2, 1'b1);
    strobe_pulse(6'h34, 2, 2, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    check("t5_pat_count", fifo_count, 3'd2);
    check("t5_pat_tvalid", m_axis_tvalid, 1'b1);
    tick();
    mode        = 2'b00;
    ready_level = 1'b1;
    wait_drain(50, "t5_drain");
    repeat (2) tick();
    @(negedge clk);
    check("t5_end_tvalid", m_axis_tvalid, 1'b0);
    check("t5_end_count", fifo_count, 3'd0);
    tick();
`else
    // 6: mode is ignored without pattern support.
    mode        = 2'b10;
    ready_level = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_tvalid", m_axis_tvalid, 1'b0);
    end
    tick();
    strobe_pulse(6'h33, 2, 2, 1'b1);
    wait_drain(50, "t6_drain");
    mode = 2'b00;
    tick();
`endif

    repeat (3) tick();
    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
